// File: rtl/decoder_pkg.sv
// Shared types and constants for the RS(255) decoder erasure path.
package decoder_pkg;

    localparam int RS_N             = 255;
    localparam int RS_ADDR_W        = 8;
    localparam int DEF_MAX_ERASURES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        WAIT_RD = 2'd2,
        SCAN    = 2'd3
    } state_e;

    // The erasure count sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_erasure_rdpipe.sv
// Delays the read-issue info {rden, address, last} by the RAM latency so it lines up with ram_q.
module decoder_erasure_rdpipe
    import decoder_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_rden,
    input  logic [RS_ADDR_W-1:0] issue_addr,
    input  logic                 issue_last,
    output logic                 ret_rden,
    output logic [RS_ADDR_W-1:0] ret_addr,
    output logic                 ret_last
);

    logic                 rden_sr [RD_LATENCY];
    logic                 last_sr [RD_LATENCY];
    logic [RS_ADDR_W-1:0] addr_sr [RD_LATENCY];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rden_sr[i] <= 1'b0;
                last_sr[i] <= 1'b0;
            end
        end else begin
            rden_sr[0] <= issue_rden;
            last_sr[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rden_sr[i] <= rden_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    // The address is only meaningful when qualified by rden, so it carries no reset.
    always_ff @(posedge clock) begin
        addr_sr[0] <= issue_addr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            addr_sr[i] <= addr_sr[i-1];
        end
    end

    assign ret_rden = rden_sr[RD_LATENCY-1];
    assign ret_last = last_sr[RD_LATENCY-1];
    assign ret_addr = addr_sr[RD_LATENCY-1];

endmodule

// File: rtl/decoder_erasure_ctrl.sv
// Erasure-flag RAM sequencer: fills one flag per symbol, counts erasures,
// then scans the RAM and emits the index of each erased symbol.
module decoder_erasure_ctrl
    import decoder_pkg::*;
#(
    parameter int N            = RS_N,
    parameter int MAX_ERASURES = DEF_MAX_ERASURES,
    parameter int RD_LATENCY   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_erasure,
    output logic                 in_ready,
    output logic                 cw_count_valid,
    output logic [7:0]           cw_erasure_count,
    output logic                 too_many,
    output logic                 sop_err,
    input  logic                 scan_start,
    output logic                 loc_valid,
    output logic [RS_ADDR_W-1:0] loc_pos,
    output logic                 scan_done,
    output logic                 ram_data,
    output logic                 ram_wren,
    output logic [RS_ADDR_W-1:0] ram_wraddress,
    output logic [RS_ADDR_W-1:0] ram_rdaddress,
    output logic                 ram_rden,
    input  logic                 ram_q
);

    localparam logic [RS_ADDR_W-1:0] LAST_ADDR = RS_ADDR_W'(N - 1);

    state_e               state;
    logic [RS_ADDR_W-1:0] idx;
    logic [7:0]           count;

    logic                 accept;
    logic [RS_ADDR_W-1:0] wr_addr;
    logic [7:0]           count_nxt;
    logic                 fill_last;
    logic                 issue_last;
    logic                 ret_rden;
    logic [RS_ADDR_W-1:0] ret_addr;
    logic                 ret_last;

    // A sop always lands at address 0, whether starting fresh or restarting a fill.
    always_comb begin
        accept    = in_valid & ~reset &
                    (((state == IDLE) & in_sop) | (state == FILL));
        wr_addr   = in_sop ? '0 : idx;
        count_nxt = sat_inc(in_sop ? 8'd0 : count, in_erasure);
        fill_last = accept & (wr_addr == LAST_ADDR);
    end

    assign in_ready      = (state == IDLE) | (state == FILL);
    assign ram_wren      = accept;
    assign ram_data      = accept & in_erasure;
    assign ram_wraddress = accept ? wr_addr : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            count            <= '0;
            cw_count_valid   <= 1'b0;
            cw_erasure_count <= '0;
            too_many         <= 1'b0;
            sop_err          <= 1'b0;
            scan_done        <= 1'b0;
            ram_rden         <= 1'b0;
            ram_rdaddress    <= '0;
        end else begin
            cw_count_valid <= 1'b0;
            sop_err        <= 1'b0;
            scan_done      <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        idx     <= wr_addr + 1'b1;
                        count   <= count_nxt;
                        sop_err <= in_sop & (state == FILL);
                        if (fill_last) begin
                            cw_count_valid   <= 1'b1;
                            cw_erasure_count <= count_nxt;
                            too_many         <= (int'(count_nxt) > MAX_ERASURES);
                            state            <= WAIT_RD;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WAIT_RD: begin
                    if (scan_start) begin
                        if (too_many) begin
                            scan_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ram_rden      <= 1'b1;
                            ram_rdaddress <= '0;
                            state         <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (ram_rden) begin
                        if (ram_rdaddress == LAST_ADDR) begin
                            ram_rden <= 1'b0;
                        end else begin
                            ram_rdaddress <= ram_rdaddress + 1'b1;
                        end
                    end
                    // Done strobes one cycle after the final read data is back.
                    if (ret_last) begin
                        scan_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign issue_last = ram_rden & (ram_rdaddress == LAST_ADDR);

    decoder_erasure_rdpipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .clock      (clock),
        .reset      (reset),
        .issue_rden (ram_rden),
        .issue_addr (ram_rdaddress),
        .issue_last (issue_last),
        .ret_rden   (ret_rden),
        .ret_addr   (ret_addr),
        .ret_last   (ret_last)
    );

    assign loc_valid = ret_rden & ram_q;
    assign loc_pos   = loc_valid ? ret_addr : '0;

endmodule
